fnd_time_display: RTL and testbench

Display back-end for the time-clock counter. Consumes the binary hour/min/sec/msec fields and time-multiplexes them onto a 4-digit common-anode 7-segment (FND) module, showing either HH.MM or SS.cc. A debounced push-button selects the display mode. Inputs are snapshotted once per scan frame so a digit pair is never torn mid-frame.

---
 rtl/fnd_time_display_if.sv | 24 ++
 rtl/fnd_time_display.sv | 205 ++++++++++++++++++++
 tb/tb_fnd_time_display.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fnd_time_display_if.sv
// fnd_time_display_if: time fields, mode button and FND drive lines of the
// 4-digit 7-segment display back-end. The master side supplies the time
// fields and the button; the slave side (the display block) drives the digit
// enables, segment font and current display mode.
interface fnd_time_display_if;
    logic [5:0] i_hour;
    logic [5:0] i_min;
    logic [5:0] i_sec;
    logic [6:0] i_msec;
    logic       i_mode_btn;
    logic [3:0] o_fnd_com;
    logic [7:0] o_fnd_font;
    logic       o_mode;

    modport master (
        output i_hour, i_min, i_sec, i_msec, i_mode_btn,
        input  o_fnd_com, o_fnd_font, o_mode
    );

    modport slave (
        input  i_hour, i_min, i_sec, i_msec, i_mode_btn,
        output o_fnd_com, o_fnd_font, o_mode
    );
endinterface

// File: rtl/fnd_time_display.sv
// fnd_time_display: multiplexes HH.MM or SS.cc onto a 4-digit common-anode
// 7-segment module. The time fields and the display mode are snapshotted once
// per scan frame, so a digit pair never mixes two different input values.
// A debounced push-button toggles the display mode.
// Optional feature: define FND_DOT_BLINK_EN to blink the d2 decimal point at
// 1 Hz (lit while snapshot msec < 50); undefined, that point is always lit.
module fnd_time_display #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input logic             i_clk,
    input logic             i_reset,
    fnd_time_display_if.slave bus
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [3:0]       DASH     = 4'hA;

    // Units digit of a field (fields up to 127).
    function automatic logic [3:0] ones_of(input logic [6:0] v);
        logic [6:0] r;
        r = v % 7'd10;
        return r[3:0];
    endfunction

    // Tens digit of a field (only meaningful for values below 100).
    function automatic logic [3:0] tens_of(input logic [6:0] v);
        logic [6:0] r;
        r = v / 7'd10;
        return r[3:0];
    endfunction

    // Active-low segment pattern {dp,g,f,e,d,c,b,a}, decimal point off.
    function automatic logic [7:0] font_of(input logic [3:0] d);
        logic [7:0] f;
        case (d)
            4'd0:    f = 8'hC0;
            4'd1:    f = 8'hF9;
            4'd2:    f = 8'hA4;
            4'd3:    f = 8'hB0;
            4'd4:    f = 8'h99;
            4'd5:    f = 8'h92;
            4'd6:    f = 8'h82;
            4'd7:    f = 8'hF8;
            4'd8:    f = 8'h80;
            4'd9:    f = 8'h90;
            4'hA:    f = 8'hBF;
            default: f = 8'hFF;
        endcase
        return f;
    endfunction

    logic [PRE_W-1:0] pre_cnt_r;
    logic             tick_s;
    logic [1:0]       idx_r;
    logic [1:0]       idx_next_s;
    logic             started_r;
    logic             do_snap_s;
    logic [5:0]       snap_hour_r, snap_min_r, snap_sec_r;
    logic [6:0]       snap_msec_r;
    logic             snap_mode_r;
    logic [5:0]       hour_s, min_s, sec_s;
    logic [6:0]       msec_s;
    logic             mode_s;
    logic [3:0]       digit_s;
    logic             dp_on_s;
    logic [7:0]       font_s;
    logic [3:0]       com_s;
    logic [3:0]       fnd_com_r;
    logic [7:0]       fnd_font_r;
    logic             sync1_r, sync2_r;
    logic             btn_acc_r;
    logic [DEB_W-1:0] deb_cnt_r;
    logic             mode_r;

    assign tick_s = (pre_cnt_r == PRE_LAST);

    // Scan prescaler: free-running 0..SCAN_DIV-1, wraps on the tick.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pre_cnt_r <= {PRE_W{1'b0}};
        end else if (tick_s) begin
            pre_cnt_r <= {PRE_W{1'b0}};
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1);
        end
    end

    // Next digit index, snapshot decision and the values seen by the new digit.
    // The first tick after reset shows d0 and takes a fresh snapshot.
    always_comb begin
        idx_next_s = 2'd0;
        do_snap_s  = 1'b0;
        if (started_r) begin
            idx_next_s = idx_r + 2'd1;
            do_snap_s  = tick_s && (idx_r == 2'd3);
        end else begin
            idx_next_s = 2'd0;
            do_snap_s  = tick_s;
        end
        hour_s = do_snap_s ? bus.i_hour     : snap_hour_r;
        min_s  = do_snap_s ? bus.i_min      : snap_min_r;
        sec_s  = do_snap_s ? bus.i_sec      : snap_sec_r;
        msec_s = do_snap_s ? bus.i_msec     : snap_msec_r;
        mode_s = do_snap_s ? mode_r         : snap_mode_r;
    end

    // Digit value, decimal point, font and enable for the digit about to show.
    always_comb begin
        digit_s = DASH;
        dp_on_s = 1'b0;
        if (mode_s == 1'b0) begin
            case (idx_next_s)
                2'd0:    digit_s = ones_of({1'b0, min_s});
                2'd1:    digit_s = tens_of({1'b0, min_s});
                2'd2:    digit_s = ones_of({1'b0, hour_s});
                2'd3:    digit_s = tens_of({1'b0, hour_s});
                default: digit_s = DASH;
            endcase
        end else begin
            case (idx_next_s)
                2'd0:    digit_s = (msec_s >= 7'd100) ? DASH : ones_of(msec_s);
                2'd1:    digit_s = (msec_s >= 7'd100) ? DASH : tens_of(msec_s);
                2'd2:    digit_s = ones_of({1'b0, sec_s});
                2'd3:    digit_s = tens_of({1'b0, sec_s});
                default: digit_s = DASH;
            endcase
        end
        if (idx_next_s == 2'd2) begin
`ifdef FND_DOT_BLINK_EN
            dp_on_s = (msec_s < 7'd50);
`else
            dp_on_s = 1'b1;
`endif
        end else begin
            dp_on_s = 1'b0;
        end
        font_s = font_of(digit_s) & {~dp_on_s, 7'h7F};
        com_s  = ~(4'b0001 << idx_next_s);
    end

    // Digit scan state, frame snapshot and registered FND outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            idx_r       <= 2'd0;
            started_r   <= 1'b0;
            snap_hour_r <= 6'd0;
            snap_min_r  <= 6'd0;
            snap_sec_r  <= 6'd0;
            snap_msec_r <= 7'd0;
            snap_mode_r <= 1'b0;
            fnd_com_r   <= 4'b1111;
            fnd_font_r  <= 8'hFF;
        end else if (tick_s) begin
            idx_r       <= idx_next_s;
            started_r   <= 1'b1;
            snap_hour_r <= hour_s;
            snap_min_r  <= min_s;
            snap_sec_r  <= sec_s;
            snap_msec_r <= msec_s;
            snap_mode_r <= mode_s;
            fnd_com_r   <= com_s;
            fnd_font_r  <= font_s;
        end
    end

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= bus.i_mode_btn;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYC stable clocks; an
    // accepted press (rising level) toggles the display mode.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            deb_cnt_r <= {DEB_W{1'b0}};
            btn_acc_r <= 1'b0;
            mode_r    <= 1'b0;
        end else if (sync2_r != btn_acc_r) begin
            if (deb_cnt_r == DEB_LAST) begin
                deb_cnt_r <= {DEB_W{1'b0}};
                btn_acc_r <= sync2_r;
                mode_r    <= mode_r ^ sync2_r;
            end else begin
                deb_cnt_r <= deb_cnt_r + DEB_W'(1);
            end
        end else begin
            deb_cnt_r <= {DEB_W{1'b0}};
        end
    end

    assign bus.o_fnd_com  = fnd_com_r;
    assign bus.o_fnd_font = fnd_font_r;
    assign bus.o_mode     = mode_r;

endmodule

// File: tb/tb_fnd_time_display.sv
// Directed bench for fnd_time_display with SCAN_DIV = 4, DEBOUNCE_CYC = 8.
// A digit tick lands every 4 clocks; a full frame takes 16 clocks.
module tb_fnd_time_display;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    fnd_time_display_if dut_if ();

    fnd_time_display #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CYC (8)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse reset and run to the first tick (d0 of a fresh frame).
    task automatic reset_and_first();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(4);
    endtask

    // Press the button long enough to toggle, release, land on a frame start.
    task automatic enter_mode1();
        dut_if.i_mode_btn = 1'b1;
        step(12);
        dut_if.i_mode_btn = 1'b0;
        step(4);
    endtask

    task automatic test_reset();
        dut_if.i_hour = 6'd12; dut_if.i_min = 6'd34;
        dut_if.i_sec = 6'd5;   dut_if.i_msec = 7'd7;
        rst = 1'b1;
        step(2);
        n_checks++;
        if (dut_if.o_fnd_com !== 4'b1111) $display("FAIL reset_com got %b want 1111", dut_if.o_fnd_com);
        else n_pass++;
        n_checks++;
        if (dut_if.o_fnd_font !== 8'hFF) $display("FAIL reset_font got %h want ff", dut_if.o_fnd_font);
        else n_pass++;
        n_checks++;
        if (dut_if.o_mode !== 1'b0) $display("FAIL reset_mode got %b want 0", dut_if.o_mode);
        else n_pass++;
        rst = 1'b0;
        step(3);
        n_checks++;
        if ({dut_if.o_fnd_com, dut_if.o_fnd_font} !== {4'b1111, 8'hFF})
            $display("FAIL pre_tick got %b/%h want 1111/ff", dut_if.o_fnd_com, dut_if.o_fnd_font);
        else n_pass++;
        step(1);
        n_checks++;
        if ({dut_if.o_fnd_com, dut_if.o_fnd_font} !== {4'b1110, 8'h99})
            $display("FAIL first_tick got %b/%h want 1110/99", dut_if.o_fnd_com, dut_if.o_fnd_font);
        else n_pass++;
    endtask

    task automatic test_mode0_scan();
        logic [3:0] exp_com [5];
        logic [7:0] exp_font[5];
        exp_com[0] = 4'b1110; exp_font[0] = 8'h99;
        exp_com[1] = 4'b1101; exp_font[1] = 8'hB0;
        exp_com[2] = 4'b1011; exp_font[2] = 8'h24;
        exp_com[3] = 4'b0111; exp_font[3] = 8'hF9;
        exp_com[4] = 4'b1110; exp_font[4] = 8'h99;
        dut_if.i_hour = 6'd12; dut_if.i_min = 6'd34;
        reset_and_first();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step(4);
            n_checks++;
            if ({dut_if.o_fnd_com, dut_if.o_fnd_font} !== {exp_com[i], exp_font[i]})
                $display("FAIL mode0_digit%0d got %b/%h want %b/%h", i,
                         dut_if.o_fnd_com, dut_if.o_fnd_font, exp_com[i], exp_font[i]);
            else n_pass++;
        end
    endtask

    task automatic test_mode_button();
        logic [3:0] exp_com [4];
        logic [7:0] exp_font[4];
        exp_com[0] = 4'b1110; exp_font[0] = 8'hF8;
        exp_com[1] = 4'b1101; exp_font[1] = 8'hC0;
        exp_com[2] = 4'b1011; exp_font[2] = 8'h12;
        exp_com[3] = 4'b0111; exp_font[3] = 8'hC0;
        dut_if.i_sec = 6'd5; dut_if.i_msec = 7'd7;
        reset_and_first();
        dut_if.i_mode_btn = 1'b1;
        step(9);
        n_checks++;
        if (dut_if.o_mode !== 1'b0) $display("FAIL btn_early got %b want 0", dut_if.o_mode);
        else n_pass++;
        step(1);
        n_checks++;
        if (dut_if.o_mode !== 1'b1) $display("FAIL btn_toggle got %b want 1", dut_if.o_mode);
        else n_pass++;
        step(10);
        dut_if.i_mode_btn = 1'b0;
        step(12);
        n_checks++;
        if (dut_if.o_mode !== 1'b1) $display("FAIL btn_release got %b want 1", dut_if.o_mode);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(4);
            n_checks++;
            if ({dut_if.o_fnd_com, dut_if.o_fnd_font} !== {exp_com[i], exp_font[i]})
                $display("FAIL mode1_digit%0d got %b/%h want %b/%h", i,
                         dut_if.o_fnd_com, dut_if.o_fnd_font, exp_com[i], exp_font[i]);
            else n_pass++;
        end
        dut_if.i_mode_btn = 1'b1;
        step(3);
        dut_if.i_mode_btn = 1'b0;
        step(13);
        n_checks++;
        if (dut_if.o_mode !== 1'b1) $display("FAIL short_pulse got %b want 1", dut_if.o_mode);
        else n_pass++;
    endtask

    task automatic test_mid_frame();
        dut_if.i_hour = 6'd12; dut_if.i_min = 6'd34;
        reset_and_first();
        step(4);
        dut_if.i_min = 6'd56; dut_if.i_hour = 6'd7;
        step(4);
        n_checks++;
        if ({dut_if.o_fnd_com, dut_if.o_fnd_font} !== {4'b1011, 8'h24})
            $display("FAIL mid_d2 got %b/%h want 1011/24", dut_if.o_fnd_com, dut_if.o_fnd_font);
        else n_pass++;
        step(4);
        n_checks++;
        if ({dut_if.o_fnd_com, dut_if.o_fnd_font} !== {4'b0111, 8'hF9})
            $display("FAIL mid_d3 got %b/%h want 0111/f9", dut_if.o_fnd_com, dut_if.o_fnd_font);
        else n_pass++;
        step(4);
        n_checks++;
        if ({dut_if.o_fnd_com, dut_if.o_fnd_font} !== {4'b1110, 8'h82})
            $display("FAIL next_d0 got %b/%h want 1110/82", dut_if.o_fnd_com, dut_if.o_fnd_font);
        else n_pass++;
        step(8);
        n_checks++;
        if ({dut_if.o_fnd_com, dut_if.o_fnd_font} !== {4'b1011, 8'h78})
            $display("FAIL next_d2 got %b/%h want 1011/78", dut_if.o_fnd_com, dut_if.o_fnd_font);
        else n_pass++;
    endtask

    task automatic test_dash_and_dot();
        logic [7:0] exp_d2_127;
        logic [7:0] exp_d2_70;
`ifdef FND_DOT_BLINK_EN
        exp_d2_127 = 8'h92;
        exp_d2_70  = 8'h92;
`else
        exp_d2_127 = 8'h12;
        exp_d2_70  = 8'h12;
`endif
        dut_if.i_sec = 6'd5; dut_if.i_msec = 7'd127;
        reset_and_first();
        enter_mode1();
        n_checks++;
        if ({dut_if.o_fnd_com, dut_if.o_fnd_font} !== {4'b1110, 8'hBF})
            $display("FAIL dash_d0 got %b/%h want 1110/bf", dut_if.o_fnd_com, dut_if.o_fnd_font);
        else n_pass++;
        dut_if.i_msec = 7'd30;
        step(4);
        n_checks++;
        if ({dut_if.o_fnd_com, dut_if.o_fnd_font} !== {4'b1101, 8'hBF})
            $display("FAIL dash_d1 got %b/%h want 1101/bf", dut_if.o_fnd_com, dut_if.o_fnd_font);
        else n_pass++;
        step(4);
        n_checks++;
        if (dut_if.o_fnd_font !== exp_d2_127)
            $display("FAIL dot_127 got %h want %h", dut_if.o_fnd_font, exp_d2_127);
        else n_pass++;
        step(8);
        n_checks++;
        if ({dut_if.o_fnd_com, dut_if.o_fnd_font} !== {4'b1110, 8'hC0})
            $display("FAIL msec30_d0 got %b/%h want 1110/c0", dut_if.o_fnd_com, dut_if.o_fnd_font);
        else n_pass++;
        step(4);
        n_checks++;
        if (dut_if.o_fnd_font !== 8'hB0)
            $display("FAIL msec30_d1 got %h want b0", dut_if.o_fnd_font);
        else n_pass++;
        step(4);
        n_checks++;
        if (dut_if.o_fnd_font !== 8'h12)
            $display("FAIL dot_30 got %h want 12", dut_if.o_fnd_font);
        else n_pass++;
        dut_if.i_msec = 7'd70;
        step(16);
        n_checks++;
        if ({dut_if.o_fnd_com, dut_if.o_fnd_font} !== {4'b1011, exp_d2_70})
            $display("FAIL dot_70 got %b/%h want 1011/%h", dut_if.o_fnd_com, dut_if.o_fnd_font, exp_d2_70);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        dut_if.i_hour = 6'd12; dut_if.i_min = 6'd34;
        reset_and_first();
        step(8);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({dut_if.o_fnd_com, dut_if.o_fnd_font} !== {4'b1111, 8'hFF})
            $display("FAIL async_reset got %b/%h want 1111/ff", dut_if.o_fnd_com, dut_if.o_fnd_font);
        else n_pass++;
        dut_if.i_hour = 6'd9; dut_if.i_min = 6'd8;
        step(2);
        rst = 1'b0;
        step(3);
        n_checks++;
        if ({dut_if.o_fnd_com, dut_if.o_fnd_font} !== {4'b1111, 8'hFF})
            $display("FAIL restart_hold got %b/%h want 1111/ff", dut_if.o_fnd_com, dut_if.o_fnd_font);
        else n_pass++;
        step(1);
        n_checks++;
        if ({dut_if.o_fnd_com, dut_if.o_fnd_font} !== {4'b1110, 8'h80})
            $display("FAIL restart_d0 got %b/%h want 1110/80", dut_if.o_fnd_com, dut_if.o_fnd_font);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        dut_if.i_hour = 6'd0; dut_if.i_min = 6'd0;
        dut_if.i_sec = 6'd0;  dut_if.i_msec = 7'd0;
        dut_if.i_mode_btn = 1'b0;
        step(1);
        test_reset();
        test_mode0_scan();
        test_mode_button();
        test_mid_frame();
        test_dash_and_dot();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
